// File: rtl/mult4u_arb_pkg.sv
// mult4u_arb_pkg
//   Shared definitions for the round-robin multiplier arbiter: the FSM state
//   enum and the operand, product and statistics-counter widths.
package mult4u_arb_pkg;

  localparam int OPND_W = 4;   // width of each multiplier operand
  localparam int PROD_W = 8;   // width of the full unsigned product
  localparam int CNT_W  = 16;  // width of each per-requester grant counter

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_e;

endpackage

// File: rtl/mult4u_normal_ripple.sv
// mult4u_normal_ripple
//   Combinational 4x4 unsigned array multiplier. Each partial-product row is
//   added into a running sum through an explicit ripple-carry chain.
//   Ports:
//     multiplicand [3:0] in  - operand a
//     multiplier   [3:0] in  - operand b
//     product      [7:0] out - a*b, full width
module mult4u_normal_ripple
  import mult4u_arb_pkg::*;
(
  input  logic [OPND_W-1:0] multiplicand,
  input  logic [OPND_W-1:0] multiplier,
  output logic [PROD_W-1:0] product
);

  logic [PROD_W-1:0] pp [OPND_W];
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] sum_row;
  logic              carry;

  // Row gi is the multiplicand gated by multiplier bit gi, weighted by 2^gi.
  for (genvar gi = 0; gi < OPND_W; gi++) begin : gen_pp
    assign pp[gi] = PROD_W'(multiplicand & {OPND_W{multiplier[gi]}}) << gi;
  end

  always_comb begin
    acc     = '0;
    sum_row = '0;
    carry   = 1'b0;
    for (int r = 0; r < OPND_W; r++) begin
      carry = 1'b0;
      for (int j = 0; j < PROD_W; j++) begin
        sum_row[j] = acc[j] ^ pp[r][j] ^ carry;
        carry      = (acc[j] & pp[r][j]) | (carry & (acc[j] ^ pp[r][j]));
      end
      // The final carry out is always zero: 15*15 fits in 8 bits.
      acc = sum_row;
    end
    product = acc;
  end

endmodule

// File: rtl/mult4u_rr_arbiter.sv
// mult4u_rr_arbiter
//   NUM_REQ requesters share one 4x4 unsigned multiplier. A round-robin
//   arbiter grants one requester while idle; the operands are registered,
//   multiplied for one cycle, and the result is held until downstream accepts.
//   One result every 3 cycles at best (IDLE -> COMPUTE -> RESP).
//   Ports:
//     clk, rst          - clock, synchronous active-high reset
//     req_valid/ready   - per-requester handshake (ready one-hot, combinational)
//     req_a, req_b      - packed 4-bit operands, requester i at [4i+3:4i]
//     rsp_valid/ready   - response handshake
//     rsp_product       - 8-bit product
//     rsp_id            - requester owning rsp_product
//     grant_cnt         - per-requester 16-bit saturating grant counters,
//                         present only when MULT4U_ARB_STATS_EN is defined
module mult4u_rr_arbiter
  import mult4u_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*OPND_W-1:0]   req_a,
  input  logic [NUM_REQ*OPND_W-1:0]   req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [PROD_W-1:0]           rsp_product,
  output logic [ID_W-1:0]             rsp_id
`ifdef MULT4U_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]    grant_cnt
`endif
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [OPND_W-1:0]   op_a_q, op_a_d;
  logic [OPND_W-1:0]   op_b_q, op_b_d;
  logic [ID_W-1:0]     op_id_q, op_id_d;
  logic [PROD_W-1:0]   rsp_product_q, rsp_product_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;

  logic [PROD_W-1:0]   mul_product;
  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic                accept;
  int                  cand;

  // Scan requesters starting at rr_ptr and wrapping; first valid one wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Reset also masks the grant so nothing is accepted during a reset cycle.
  assign accept = (state_q == IDLE) && grant_found && !rst;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gen_ready
    assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_id_d       = op_id_q;
    rsp_product_d = rsp_product_q;
    rsp_id_d      = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d   = req_a[grant_idx*OPND_W +: OPND_W];
          op_b_d   = req_b[grant_idx*OPND_W +: OPND_W];
          op_id_d  = grant_idx;
          rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = COMPUTE;
        end
      end
      COMPUTE: begin
        rsp_product_d = mul_product;
        rsp_id_d      = op_id_q;
        state_d       = RESP;
      end
      RESP: begin
        // No bypass: a new grant waits for the IDLE cycle after the handshake.
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_id_q       <= '0;
      rsp_product_q <= '0;
      rsp_id_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_id_q       <= op_id_d;
      rsp_product_q <= rsp_product_d;
      rsp_id_q      <= rsp_id_d;
    end
  end

  // The multiplier sees only the registered operands, never the request bus.
  mult4u_normal_ripple u_mul (
    .multiplicand (op_a_q),
    .multiplier   (op_b_q),
    .product      (mul_product)
  );

  assign rsp_valid   = (state_q == RESP);
  assign rsp_product = rsp_product_q;
  assign rsp_id      = rsp_id_q;

`ifdef MULT4U_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gen_stats
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (req_ready[gi] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_mult4u_rr_arbiter.sv
// tb_mult4u_rr_arbiter
//   Scoreboard bench: a reference model predicts each grant from the
//   round-robin rule and pushes the expected response; a monitor compares
//   every cycle in which the DUT presents rsp_valid. Define
//   MULT4U_ARB_STATS_EN to also exercise the grant counters.
module tb_mult4u_rr_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*4-1:0] req_a;
  logic [N*4-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [7:0]     rsp_product;
  logic [1:0]     rsp_id;
`ifdef MULT4U_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  mult4u_rr_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_id      (rsp_id)
`ifdef MULT4U_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  typedef struct {
    int id;
    int prod;
    int acc_c;
  } exp_t;

  exp_t sb[$];
  int   dut_gnt_id[$];
  int   dut_gnt_cyc[$];

  // Reference model: one transaction in flight, busy from acceptance until
  // the cycle rsp_ready is seen at least two cycles after acceptance.
  bit m_busy = 1'b0;
  int m_ptr  = 0;
  int m_acc_c;
  int m_g;
  int m_i;
  int m_exp_rdy;

  always @(negedge clk) begin
    if (rst) begin
      chk("ready_in_reset", int'(req_ready), 0);
      m_busy = 1'b0;
      m_ptr  = 0;
      sb.delete();
    end else begin
      m_g = -1;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          m_i = (m_ptr + k) % N;
          if (m_g < 0 && req_valid[m_i]) m_g = m_i;
        end
      end
      m_exp_rdy = (m_g >= 0) ? (1 << m_g) : 0;
      chk("req_ready", int'(req_ready), m_exp_rdy);
      for (int k = 0; k < N; k++) begin
        if (req_ready[k]) begin
          dut_gnt_id.push_back(k);
          dut_gnt_cyc.push_back(cyc);
        end
      end
      if (m_g >= 0) begin
        sb.push_back('{id: m_g,
                       prod: int'(req_a[m_g*4 +: 4]) * int'(req_b[m_g*4 +: 4]),
                       acc_c: cyc});
        m_busy  = 1'b1;
        m_acc_c = cyc;
        m_ptr   = (m_g + 1) % N;
      end else if (m_busy && cyc >= m_acc_c + 2 && rsp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // Monitor: runs just after the model in the same half-cycle.
  bit front_seen = 1'b0;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      front_seen = 1'b0;
    end else if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp_valid", 1, 0);
      end else begin
        if (!front_seen) begin
          chk("latency", cyc - sb[0].acc_c, 2);
          front_seen = 1'b1;
        end
        chk("rsp_id", int'(rsp_id), sb[0].id);
        chk("rsp_product", int'(rsp_product), sb[0].prod);
        if (rsp_ready) begin
          $display("rsp id=%0d product=%0d cycle=%0d", rsp_id, rsp_product, cyc);
          void'(sb.pop_front());
          front_seen = 1'b0;
        end
      end
    end else if (sb.size() > 0 && cyc >= sb[0].acc_c + 2) begin
      chk("missing_rsp_valid", 0, 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_product", int'(rsp_product), 0);
    chk("reset_rsp_id", int'(rsp_id), 0);
    step();
    rst = 1'b0;

`ifdef MULT4U_ARB_STATS_EN
    repeat (3) begin
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      repeat (3) step();
    end
    @(negedge clk);
    chk("stats_cnt1", int'(grant_cnt[31:16]), 3);
    chk("stats_cnt0", int'(grant_cnt[15:0]), 0);
    chk("stats_cnt2", int'(grant_cnt[47:32]), 0);
    chk("stats_cnt3", int'(grant_cnt[63:48]), 0);
    dut.gen_stats[0].cnt_q = 16'hFFFF;
    step();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (3) step();
    @(negedge clk);
    chk("stats_saturate", int'(grant_cnt[15:0]), 16'hFFFF);
    step();
`endif

    // Single request, maximum operands.
    req_valid  = 4'b0001;
    req_a[3:0] = 4'd15;
    req_b[3:0] = 4'd15;
    step();
    req_valid = '0;
    repeat (4) step();

    // Fairness from a fresh pointer.
    rst = 1'b1;
    step();
    rst = 1'b0;
    dut_gnt_id.delete();
    dut_gnt_cyc.delete();
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    req_valid = 4'hF;
    repeat (15) step();
    req_valid = '0;
    repeat (4) step();
    if (dut_gnt_id.size() < 5) begin
      chk("fair_grant_count", dut_gnt_id.size(), 5);
    end else begin
      for (int i = 0; i < 5; i++) chk("fair_order", dut_gnt_id[i], exp_order[i]);
      for (int i = 0; i < 4; i++) chk("fair_spacing", dut_gnt_cyc[i+1] - dut_gnt_cyc[i], 3);
    end

    // Backpressure on requester 2; request stays asserted while busy.
    req_valid   = 4'b0100;
    req_a[11:8] = 4'd7;
    req_b[11:8] = 4'd9;
    rsp_ready   = 1'b0;
    step();
    step();
    repeat (5) step();
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (3) step();

    // Reset while in COMPUTE.
    req_valid  = 4'b0001;
    req_a[3:0] = 4'd5;
    req_b[3:0] = 4'd6;
    step();
    rst       = 1'b1;
    req_valid = '0;
    step();
    rst       = 1'b0;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("post_reset_rsp_valid", int'(rsp_valid), 0);
    chk("post_reset_grant", int'(req_ready), 2);
    step();
    req_valid = '0;
    repeat (4) step();

    // Exhaustive products through requester 3.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int w;
        req_a[15:12] = 4'(a);
        req_b[15:12] = 4'(b);
        req_valid    = 4'b1000;
        w = 0;
        @(negedge clk);
        while (!req_ready[3] && w < 10) begin
          @(negedge clk);
          w++;
        end
        if (w >= 10) chk("exhaustive_timeout", 0, 1);
        step();
      end
    end
    req_valid = '0;
    repeat (4) step();

    // Random masks, operands, backpressure and occasional reset.
    repeat (400) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = 4'($urandom);
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) step();
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mult4u_rr_arbiter.md
MULT4U_RR_ARBITER -- requirements
Module: mult4u_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one 4x4 unsigned multiplier (legal range 2..8).
REQ-002 SHALL have localparam ID_W, default $clog2(NUM_REQ), giving the requester-ID width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: per-requester operand valid.
REQ-006 SHALL have port req_ready, output, NUM_REQ bits: per-requester accept.
REQ-007 SHALL have port req_a, input, NUM_REQ*4 bits: multiplicands; requester i uses bits [4i+3:4i].
REQ-008 SHALL have port req_b, input, NUM_REQ*4 bits: multipliers, packed as req_a.
REQ-009 SHALL have port rsp_valid, output, 1 bit: result valid.
REQ-010 SHALL have port rsp_ready, input, 1 bit: downstream accept.
REQ-011 SHALL have port rsp_product, output, 8 bits: unsigned product.
REQ-012 SHALL have port rsp_id, output, ID_W bits: index of the requester that owns rsp_product.

Function
REQ-013 SHALL implement a state machine with states IDLE, COMPUTE and RESP.
REQ-014 In IDLE with any req_valid bit set, SHALL grant exactly one requester: the first valid index at or cyclically after rr_ptr.
REQ-015 req_ready SHALL be one-hot on the granted requester, combinational, asserted only in IDLE, and all-zero otherwise.
REQ-016 On acceptance, SHALL latch the granted operands and ID into the operand register, set rr_ptr to (grant+1) mod NUM_REQ, and enter COMPUTE.
REQ-017 In COMPUTE, SHALL drive the shared multiplier from the operand register, capture the 8-bit result and ID into the response register, and enter RESP; COMPUTE lasts exactly one cycle.
REQ-018 In RESP, SHALL hold rsp_valid=1 with rsp_product and rsp_id stable until rsp_ready=1, then return to IDLE.
REQ-019 Latency SHALL be 2 cycles: a request accepted at edge N gives rsp_valid=1 after edge N+2.
REQ-020 SHALL accept no new request in the cycle of the response handshake (no bypass); maximum throughput is one result per 3 cycles.
REQ-021 rsp_valid SHALL be 0 in IDLE and COMPUTE.
REQ-022 rsp_product SHALL equal a*b exactly, 0..225, with no truncation.
REQ-023 With no req_valid bit set in IDLE, SHALL remain in IDLE and leave rr_ptr unchanged.
REQ-024 rr_ptr SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-025 rst=1 SHALL force state IDLE, rr_ptr=0, rsp_valid=0, rsp_product=0, rsp_id=0, req_ready=0 (and statistics counters to 0 when compiled in).
REQ-026 Reset asserted in COMPUTE or RESP SHALL abort the transaction with no response emitted; the first request after reset is arbitrated from rr_ptr=0.

Configuration
REQ-027 With macro MULT4U_ARB_STATS_EN defined, SHALL add output grant_cnt, NUM_REQ*16 bits, holding one 16-bit counter per requester that increments on each acceptance and saturates at 0xFFFF.
REQ-028 Without MULT4U_ARB_STATS_EN, grant_cnt and its counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Shared package mult4u_arb_pkg SHALL hold the state enum (IDLE, COMPUTE, RESP), the operand width constant (4), the product width constant (8) and the counter width constant (16).
REQ-030 SHALL instantiate exactly one multiplier sub-module, mult4u_normal_ripple (ports multiplicand, multiplier, product), driven only from the operand register.

Verification
REQ-031 Bench SHALL cover single request: req_valid=0001, a=15, b=15 -> req_ready=0001 in the same cycle; 2 cycles later rsp_valid=1, rsp_product=225 (0xE1), rsp_id=0.
REQ-032 Bench SHALL cover fairness: req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0 with rsp_valid at 3-cycle spacing.
REQ-033 Bench SHALL cover backpressure: req 2 with a=7, b=9, rsp_ready=0 for 5 cycles -> rsp_valid=1, rsp_product=63, rsp_id=2 stable all 5 cycles; req_ready=0000 throughout.
REQ-034 Bench SHALL cover reset mid-operation: rst=1 in COMPUTE -> next cycle rsp_valid=0 and state IDLE; with req_valid=1010 the next grant is requester 1.
REQ-035 Bench SHALL cover exhaustive products: all 256 (a,b) pairs via requester 3 -> every rsp_product = a*b, including 0*x=0.
REQ-036 Bench SHALL cover statistics with MULT4U_ARB_STATS_EN defined: 3 grants to requester 1 -> grant_cnt[31:16]=3 and the other counters 0; preload a counter to 0xFFFF, grant once more -> still 0xFFFF.
